// File: rtl/hilo_acc_if.sv
// HI/LO register-pair bus: direct-write port from WB, accumulate request port
// from EX, and the read/handshake signals going back to the pipeline.
interface hilo_acc_if #(
   parameter int WIDTH = 32
);
   logic             we_hi;
   logic             we_lo;
   logic [WIDTH-1:0] hi_i;
   logic [WIDTH-1:0] lo_i;
   logic             acc_start;
   logic [1:0]       acc_op;
   logic [WIDTH-1:0] acc_a;
   logic [WIDTH-1:0] acc_b;
   logic             flush;
   logic             stall_req;
   logic             acc_done;
   logic [WIDTH-1:0] hi_o;
   logic [WIDTH-1:0] lo_o;

   // Pipeline side: drives requests, observes results.
   modport master (
      output we_hi, we_lo, hi_i, lo_i, acc_start, acc_op, acc_a, acc_b, flush,
      input  stall_req, acc_done, hi_o, lo_o
   );

   // Register-pair side.
   modport slave (
      input  we_hi, we_lo, hi_i, lo_i, acc_start, acc_op, acc_a, acc_b, flush,
      output stall_req, acc_done, hi_o, lo_o
   );
endinterface

// File: rtl/hilo_acc.sv
// HI/LO special-register pair with independent direct writes and a two-cycle
// multiply-accumulate engine (MADD/MADDU/MSUB/MSUBU).
// Edge E0 (IDLE): latch the 2*WIDTH product and the add/sub selector.
// Edge E1 (ACC) : commit {hi,lo} +/- product unless flushed, pulse acc_done.
module hilo_acc #(
   parameter int WIDTH  = 32,
   parameter int BYPASS = 1
) (
   input  logic            clk,
   input  logic            rst,
   hilo_acc_if.slave       io_hilo
);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_ACC  = 1'b1
   } state_t;

   localparam logic LP_BYPASS = (BYPASS != 0) ? 1'b1 : 1'b0;

   // Extend an operand to 2*WIDTH: zero-extend for unsigned ops, sign-extend
   // otherwise, so one modular multiply serves both flavours.
   function automatic logic [2*WIDTH-1:0] f_extend(
      input logic [WIDTH-1:0] v,
      input logic             is_unsigned
   );
      logic [2*WIDTH-1:0] ext;
      if (is_unsigned) begin
         ext = {{WIDTH{1'b0}}, v};
      end else begin
         ext = {{WIDTH{v[WIDTH-1]}}, v};
      end
      return ext;
   endfunction

   state_t             r_state;
   state_t             w_state_nxt;
   logic [WIDTH-1:0]   r_hi;
   logic [WIDTH-1:0]   r_lo;
   logic [2*WIDTH-1:0] r_prod;
   logic               r_sub;
   logic               r_acc_done;

   logic               w_start;
   logic [2*WIDTH-1:0] w_a_ext;
   logic [2*WIDTH-1:0] w_b_ext;
   logic [2*WIDTH-1:0] w_prod;
   logic [2*WIDTH-1:0] w_acc_sum;
   logic               w_stall;
   logic [WIDTH-1:0]   w_hi_rd;
   logic [WIDTH-1:0]   w_lo_rd;

   // Accept a request only when idle and not being flushed.
   assign w_start = (r_state == ST_IDLE) & io_hilo.acc_start & ~io_hilo.flush;

   // Operand extension and modular 2*WIDTH product.
   always_comb begin
      w_a_ext = f_extend(io_hilo.acc_a, io_hilo.acc_op[0]);
      w_b_ext = f_extend(io_hilo.acc_b, io_hilo.acc_op[0]);
      w_prod  = w_a_ext * w_b_ext;
   end

   // Accumulate adder/subtractor on the full HI:LO value, wrapping silently.
   always_comb begin
      if (r_sub) begin
         w_acc_sum = {r_hi, r_lo} - r_prod;
      end else begin
         w_acc_sum = {r_hi, r_lo} + r_prod;
      end
   end

   // Next-state logic and the combinational stall request.
   always_comb begin
      w_state_nxt = r_state;
      w_stall     = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_start) begin
               w_state_nxt = ST_ACC;
               w_stall     = rst;
            end else begin
               w_state_nxt = ST_IDLE;
               w_stall     = 1'b0;
            end
         end
         ST_ACC: begin
            w_state_nxt = ST_IDLE;
            w_stall     = 1'b0;
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_stall     = 1'b0;
         end
      endcase
   end

   // State register; reset or any ACC cycle lands back in IDLE.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // HI/LO, latched product and done pulse. Direct writes only land in IDLE;
   // in ACC the accumulate commit owns the registers.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_hi       <= {WIDTH{1'b0}};
         r_lo       <= {WIDTH{1'b0}};
         r_prod     <= {(2*WIDTH){1'b0}};
         r_sub      <= 1'b0;
         r_acc_done <= 1'b0;
      end else begin
         r_acc_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (io_hilo.we_hi) begin
                  r_hi <= io_hilo.hi_i;
               end
               if (io_hilo.we_lo) begin
                  r_lo <= io_hilo.lo_i;
               end
               if (w_start) begin
                  r_prod <= w_prod;
                  r_sub  <= io_hilo.acc_op[1];
               end
            end
            ST_ACC: begin
               if (!io_hilo.flush) begin
                  r_hi       <= w_acc_sum[2*WIDTH-1:WIDTH];
                  r_lo       <= w_acc_sum[WIDTH-1:0];
                  r_acc_done <= 1'b1;
               end
            end
            default: begin
               r_acc_done <= 1'b0;
            end
         endcase
      end
   end

   // Read path: forward a same-cycle direct write when bypass is enabled.
   always_comb begin
      if (LP_BYPASS && rst && (r_state == ST_IDLE) && io_hilo.we_hi) begin
         w_hi_rd = io_hilo.hi_i;
      end else begin
         w_hi_rd = r_hi;
      end
      if (LP_BYPASS && rst && (r_state == ST_IDLE) && io_hilo.we_lo) begin
         w_lo_rd = io_hilo.lo_i;
      end else begin
         w_lo_rd = r_lo;
      end
   end

   assign io_hilo.stall_req = w_stall;
   assign io_hilo.acc_done  = r_acc_done;
   assign io_hilo.hi_o      = w_hi_rd;
   assign io_hilo.lo_o      = w_lo_rd;

endmodule
